// File: rtl/m_rv32i_pkg.sv
// Shared RV32I front-end constants, fetch buffer entry type and opcode-class helper.
package m_rv32i_pkg;

  localparam int unsigned     ILEN               = 32;
  localparam logic [ILEN-1:0] NOP                = 32'h0000_0013;
  localparam logic [ILEN-1:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam int unsigned     DEFAULT_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] ir;
  } fetch_entry_t;

  typedef enum logic [2:0] {
    ITYPE_R,
    ITYPE_I,
    ITYPE_S,
    ITYPE_B,
    ITYPE_U,
    ITYPE_J,
    ITYPE_BAD
  } instr_type_e;

  // Type decoder keyed on ir[6:2].
  function automatic instr_type_e decode_type(input logic [4:0] opcode);
    instr_type_e t;
    case (opcode)
      5'b01100:                            t = ITYPE_R;
      5'b00100, 5'b00000, 5'b11001, 5'b11100: t = ITYPE_I;
      5'b01000:                            t = ITYPE_S;
      5'b11000:                            t = ITYPE_B;
      5'b01101, 5'b00101:                  t = ITYPE_U;
      5'b11011:                            t = ITYPE_J;
      default:                             t = ITYPE_BAD;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/m_fetch_fifo.sv
// Small {pc, ir} instruction buffer with push, pop, flush and occupancy count.
module m_fetch_fifo
  import m_rv32i_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Flush dominates push and pop in the same cycle.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    head  = mem_q[rd_ptr_q];
    count = count_q;
  end

endmodule

// File: rtl/m_fetch.sv
// Instruction fetch: fixed-latency imem requests into a small buffer feeding decode.
// ir[6:2] is the opcode input of the downstream type decoder (m_rv32i_pkg::decode_type).
module m_fetch
  import m_rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] pc
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;
  logic          req_epoch_q, req_epoch_d;
  logic          epoch_q, epoch_d;
  logic          issue, pop, push;
  logic [OW-1:0] pending;
  logic [CW-1:0] count;
  fetch_entry_t  head, push_data;

  always_comb begin
    ir_valid  = (count != '0);
    ir        = ir_valid ? head.ir : NOP;
    pc        = ir_valid ? head.pc : '0;
    imem_req  = issue;
    imem_addr = fetch_pc_q;
  end

  // Issue is gated by rst_n so the strobe drops as soon as reset asserts.
  // A response tagged with a stale epoch is dropped; one arriving in the
  // redirect cycle itself is removed by the flush.
  always_comb begin
    pending     = OW'(count) + OW'(inflight_q) - OW'(ir_valid && ir_ready);
    issue       = rst_n && !redirect_valid && (pending < OW'(FIFO_DEPTH));
    pop         = ir_valid && ir_ready && !redirect_valid;
    push        = inflight_q && (req_epoch_q == epoch_q);
    push_data   = '{pc: req_pc_q, ir: imem_rdata};
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    req_epoch_d = req_epoch_q;
    inflight_d  = issue;
    epoch_d     = epoch_q ^ redirect_valid;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'h3;
    end else if (issue) begin
      fetch_pc_d  = fetch_pc_q + 32'd4;
      req_pc_d    = fetch_pc_q;
      req_epoch_d = epoch_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q  <= RESET_PC & ~32'h3;
      req_pc_q    <= '0;
      inflight_q  <= 1'b0;
      req_epoch_q <= 1'b0;
      epoch_q     <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      inflight_q  <= inflight_d;
      req_epoch_q <= req_epoch_d;
      epoch_q     <= epoch_d;
    end
  end

  m_fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (redirect_valid),
    .head     (head),
    .count    (count)
  );

endmodule

// File: doc/m_fetch.md
M_FETCH -- requirements
Module: m_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2: instruction buffer entries; only 2 is supported.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 imem_req  output  1: instruction memory read strobe.
REQ-006 imem_addr  output  32: word-aligned read address; valid when imem_req=1.
REQ-007 imem_rdata  input  32: read data, valid exactly one cycle after each imem_req=1 cycle (fixed latency, no stall).
REQ-008 redirect_valid  input  1: PC redirect from branch or jump resolution.
REQ-009 redirect_pc  input  32: new fetch address; bits [1:0] ignored.
REQ-010 ir_valid  output  1: ir/pc hold a valid instruction for decode.
REQ-011 ir_ready  input  1: decode accepts the head instruction.
REQ-012 ir  output  32: instruction word feeding the type/immediate decoder.
REQ-013 pc  output  32: address of ir.

Function
REQ-014 fetch_pc register: set to RESET_PC on reset; +4 (mod 2^32) on each issue.
REQ-015 Issue (imem_req=1, imem_addr=fetch_pc) when no redirect and occupancy + inflight - pop < 2, where pop = ir_valid & ir_ready.
REQ-016 An issued request returns in the next cycle; data and its address are pushed into the FIFO at that cycle's end unless killed.
REQ-017 ir_valid = FIFO non-empty; ir and pc come from the head entry.
REQ-018 Handshake: pop on ir_valid & ir_ready; ir and pc stay stable while ir_valid=1 and ir_ready=0.
REQ-019 Latency: request issued in cycle N makes ir_valid=1 in cycle N+2 when the FIFO was empty.
REQ-020 Throughput: with ir_ready held at 1, one instruction per cycle after the first.
REQ-021 Full FIFO, no pop: no issue; no overflow is possible under any input sequence.
REQ-022 Redirect cycle: FIFO flushed; in-flight response killed (epoch bit); imem_req=0; fetch_pc <= {redirect_pc[31:2],2'b00}.
REQ-023 Cycle after redirect: issue at the redirect address, subject to REQ-015.
REQ-024 Redirect with a simultaneous pop: redirect wins; the pop is ignored and the FIFO ends empty.
REQ-025 Back-to-back redirects: the last one wins; no killed data ever reaches ir.
REQ-026 Empty FIFO: ir = 32'h0000_0013 (NOP) and pc = 0.
REQ-027 fetch_pc wraps from 32'hFFFF_FFFC to 0 with no flag.

Reset
REQ-028 On rst_n=0, immediately: imem_req=0, ir_valid=0, ir=NOP, pc=0, FIFO empty, inflight=0, epoch=0, fetch_pc=RESET_PC.
REQ-029 First cycle with rst_n=1: issue RESET_PC.
REQ-030 Reset asserted mid-operation: all state is discarded; a response due in the next cycle is ignored.

Structure
REQ-031 Shared package m_rv32i_pkg: NOP constant, default RESET_PC, FIFO_DEPTH, ILEN=32.
REQ-032 Sub-module m_fetch_fifo: 2-entry {pc,ir} buffer with push, pop, flush, count.
REQ-033 Top-level tie-in: ir[6:2] drives the opcode input of the existing type decoder.

Verification
REQ-034 Reset release, ir_ready=1, memory mem[i]=i -> imem_addr 0,4,8... one per cycle; ir_valid from cycle 2; pc/ir pairs (0,0),(4,1),(8,2) in order.
REQ-035 ir_ready=0 for 5 cycles after the first valid -> imem_req stops after 2 outstanding; ir/pc stay at (0,0); on release, no instruction is lost or duplicated.
REQ-036 redirect_valid with redirect_pc=32'h0000_0103 while 2 are buffered -> ir_valid=0 next cycle; next imem_addr=32'h100; next ir/pc is mem[0x100]/0x100.
REQ-037 Redirect in the same cycle as a pop, then a second redirect to 0x200 one cycle later -> no ir from 0x100 stream or older appears; first valid pc=0x200.
REQ-038 RESET_PC=32'hFFFF_FFF8, ir_ready=1 -> pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 rst_n pulsed low mid-stream -> outputs return to reset values asynchronously; refetch starts at RESET_PC.
